// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the pipeline and the muldiv_seq HI/LO unit.
// The pipeline side drives requests; the unit reports status and the HI/LO registers.
interface muldiv_seq_if #(
  parameter int DATA_W = 32
);
  logic              Start;
  logic [1:0]        Op;
  logic [DATA_W-1:0] Rdata1;
  logic [DATA_W-1:0] Rdata2;
  logic              MtHi;
  logic              MtLo;
  logic [DATA_W-1:0] Wdata;
  logic              MfReq;
  logic              Busy;
  logic              Done;
  logic              DivZero;
  logic              Stall;
  logic [DATA_W-1:0] HI;
  logic [DATA_W-1:0] LO;

  modport master (
    output Start, Op, Rdata1, Rdata2, MtHi, MtLo, Wdata, MfReq,
    input  Busy, Done, DivZero, Stall, HI, LO
  );

  modport slave (
    input  Start, Op, Rdata1, Rdata2, MtHi, MtLo, Wdata, MfReq,
    output Busy, Done, DivZero, Stall, HI, LO
  );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential MULT/MULTU/DIV/DIVU unit with HI/LO registers (32-step shift-add / restoring divide).
// Define MULDIV_SEQ_FAST_MULT_EN to compute multiplies in a single step with a full multiplier.
module muldiv_seq #(
  parameter int DATA_W = 32
) (
  input  logic         CLK,
  input  logic         RST_N,
  muldiv_seq_if.slave  bus
);

  localparam int PW    = 2 * DATA_W;
  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

`ifdef MULDIV_SEQ_FAST_MULT_EN
  localparam state_t MUL_ENTRY = FIX;
`else
  localparam state_t MUL_ENTRY = MUL;
`endif

  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v,
                                                  input logic is_signed);
    logic [DATA_W-1:0] r;
    r = v;
    if (is_signed && (v < 0)) r = -v;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + DATA_W'(1)) : v;
  endfunction

  function automatic logic [PW-1:0] neg_pw(input logic [PW-1:0] v, input logic neg);
    return neg ? (~v + PW'(1)) : v;
  endfunction

  state_t             state, state_nxt;
  logic [PW-1:0]      acc;
  logic [DATA_W-1:0]  opb;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op_q;
  logic               sign_a, sign_b;
  logic [DATA_W-1:0]  hi_r, lo_r;
  logic               done_r, dz_r;

  logic               busy, load, fix, mt_en, last_step;
  logic               is_mul_q, div_zero;
  logic [DATA_W:0]    mul_sum;
  logic [DATA_W:0]    div_shift;
  logic [DATA_W+1:0]  div_trial;
  logic [PW-1:0]      div_next;
  logic [PW-1:0]      mul_raw;
  logic [PW-1:0]      prod_fix;
  logic [DATA_W-1:0]  quo_fix, rem_fix;

  // ---- state register ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  assign last_step = (cnt == CNT_W'(DATA_W - 1));

  // ---- next-state logic ----
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.Start) state_nxt = bus.Op[1] ? DIV : MUL_ENTRY;
      MUL:  if (last_step) state_nxt = FIX;
      DIV:  if (last_step) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- output / control decode ----
  always_comb begin
    busy  = (state != IDLE);
    load  = (state == IDLE) && bus.Start;
    fix   = (state == FIX);
    mt_en = (state == IDLE) && !bus.Start;
    // Start colliding with an MT write in IDLE wins; the MT must be re-presented.
    bus.Stall = RST_N && ((busy && (bus.Start || bus.MfReq || bus.MtHi || bus.MtLo)) ||
                          ((state == IDLE) && bus.Start && (bus.MtHi || bus.MtLo)));
  end

  // One shift-add step: {HI half, multiplier} shifts right as partial sums enter the top.
  assign mul_sum   = {1'b0, acc[PW-1:DATA_W]} + (acc[0] ? {1'b0, opb} : '0);

  // One restoring step: remainder lives in the upper half, quotient shifts into the lower.
  assign div_shift = {acc[PW-1:DATA_W], acc[DATA_W-1]};
  assign div_trial = {1'b0, div_shift} - {2'b00, opb};
  assign div_next  = div_trial[DATA_W+1]
                     ? {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                     : {div_trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};

`ifdef MULDIV_SEQ_FAST_MULT_EN
  assign mul_raw = PW'(acc[DATA_W-1:0]) * PW'(opb);
`else
  assign mul_raw = acc;
`endif

  assign is_mul_q = !op_q[1];
  assign div_zero = (opb == '0);
  assign prod_fix = neg_pw(mul_raw, sign_a ^ sign_b);
  assign quo_fix  = neg_w(acc[DATA_W-1:0], sign_a ^ sign_b);
  assign rem_fix  = neg_w(acc[PW-1:DATA_W], sign_a);

  // ---- operand / iteration datapath ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc    <= '0;
      opb    <= '0;
      cnt    <= '0;
      op_q   <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else if (load) begin
      acc    <= {{DATA_W{1'b0}}, magnitude(bus.Rdata1, !bus.Op[0])};
      opb    <= magnitude(bus.Rdata2, !bus.Op[0]);
      cnt    <= '0;
      op_q   <= bus.Op;
      sign_a <= !bus.Op[0] && bus.Rdata1[DATA_W-1];
      sign_b <= !bus.Op[0] && bus.Rdata2[DATA_W-1];
    end else if (state == MUL) begin
      acc <= {mul_sum, acc[DATA_W-1:1]};
      cnt <= cnt + CNT_W'(1);
    end else if (state == DIV) begin
      acc <= div_next;
      cnt <= cnt + CNT_W'(1);
    end
  end

  // ---- architectural HI/LO and completion pulses ----
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hi_r   <= '0;
      lo_r   <= '0;
      done_r <= 1'b0;
      dz_r   <= 1'b0;
    end else begin
      done_r <= fix;
      dz_r   <= fix && !is_mul_q && div_zero;
      if (fix) begin
        if (is_mul_q) begin
          hi_r <= prod_fix[PW-1:DATA_W];
          lo_r <= prod_fix[DATA_W-1:0];
        end else if (!div_zero) begin
          hi_r <= rem_fix;
          lo_r <= quo_fix;
        end
      end else if (mt_en) begin
        if (bus.MtHi) hi_r <= bus.Wdata;
        if (bus.MtLo) lo_r <= bus.Wdata;
      end
    end
  end

  assign bus.Busy    = busy;
  assign bus.Done    = done_r;
  assign bus.DivZero = dz_r;
  assign bus.HI      = hi_r;
  assign bus.LO      = lo_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes expected HI/LO/DivZero and Done cycle,
// a negedge monitor pops and compares on every Done pulse.
module tb_muldiv_seq;

`ifdef MULDIV_SEQ_FAST_MULT_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
  } exp_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb[$];

  muldiv_seq_if #(.DATA_W(32)) bus();

  muldiv_seq #(.DATA_W(32)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (RST_N && bus.Done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: Done=1 with no pending operation (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_hi", 64'(bus.HI), 64'(e.hi));
        chk("result_lo", 64'(bus.LO), 64'(e.lo));
        chk("divzero", 64'(bus.DivZero), 64'(e.dz));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] op, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edz);
    exp_t e;
    e.hi  = ehi;
    e.lo  = elo;
    e.dz  = edz;
    e.cyc = cyc + 1 + ((op < 2) ? MUL_LAT : DIV_LAT);
    sb.push_back(e);
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    bus.Start  = 1'b1;
    bus.Op     = op;
    bus.Rdata1 = a;
    bus.Rdata2 = b;
    push_exp(op, ehi, elo, edz);
    tick();
    bus.Start = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.Done === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: Done never seen, required within 100 cycles (cycle %0d)", cyc);
    end
  endtask

  logic [1:0]  v_op[9]  = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3};
  logic [31:0] v_a[9]   = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                            32'hFFFF_FFF9, 32'h8000_0000, 32'd7, 32'hFFFF_FFFF, 32'd100};
  logic [31:0] v_b[9]   = '{32'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'd7,
                            32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h10, 32'd7};
  logic [31:0] v_hi[9]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF,
                            32'hFFFF_FFFF, 32'h0, 32'd1, 32'hF, 32'd2};
  logic [31:0] v_lo[9]  = '{32'hFFFF_FFFA, 32'h0000_0001, 32'h0, 32'hFFFF_FFF9,
                            32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFD, 32'h0FFF_FFFF, 32'd14};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_idle;
    bus.Start = 0; bus.Op = 0; bus.Rdata1 = 0; bus.Rdata2 = 0;
    bus.MtHi = 0; bus.MtLo = 0; bus.Wdata = 0; bus.MfReq = 0;

    // Reset state
    repeat (2) tick();
    chk("rst_busy", 64'(bus.Busy), 64'd0);
    chk("rst_done", 64'(bus.Done), 64'd0);
    chk("rst_divzero", 64'(bus.DivZero), 64'd0);
    chk("rst_hi", 64'(bus.HI), 64'd0);
    chk("rst_lo", 64'(bus.LO), 64'd0);
    chk("rst_stall", 64'(bus.Stall), 64'd0);
    @(negedge CLK) RST_N = 1'b1;
    tick();

    // MTHI + MTLO together, then separately
    bus.MtHi = 1; bus.MtLo = 1; bus.Wdata = 32'h0000_CAFE;
    tick();
    chk("mt_both_hi", 64'(bus.HI), 64'h0000_CAFE);
    chk("mt_both_lo", 64'(bus.LO), 64'h0000_CAFE);
    bus.MtLo = 0; bus.Wdata = 32'h11;
    tick();
    bus.MtHi = 0; bus.MtLo = 1; bus.Wdata = 32'h22;
    tick();
    bus.MtLo = 0;
    chk("mthi_only", 64'(bus.HI), 64'h11);
    chk("mtlo_only", 64'(bus.LO), 64'h22);

    // Divide by zero leaves HI/LO untouched
    start_op(2'd2, 32'd5, 32'd0, 32'h11, 32'h22, 1'b1);
    chk("busy_after_start", 64'(bus.Busy), 64'd1);
    wait_done();
    tick();

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      start_op(v_op[i], v_a[i], v_b[i], v_hi[i], v_lo[i], 1'b0);
      wait_done();
      tick();
    end

    // MfReq / MtLo while busy on a DIVU
    start_op(2'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    repeat (9) tick();
    bus.MfReq = 1; bus.MtLo = 1; bus.Wdata = 32'hDEAD_BEEF;
    seen_idle = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!bus.Busy) begin
        seen_idle = 1'b1;
        break;
      end
      chk("stall_while_busy", 64'(bus.Stall), 64'd1);
      if (i == 8) bus.MtLo = 0;
      tick();
    end
    chk("busy_dropped", 64'(seen_idle), 64'd1);
    chk("stall_after_busy", 64'(bus.Stall), 64'd0);
    bus.MfReq = 0;
    tick();

    // Reset in the middle of a MULTU
    start_op(2'd1, 32'd7, 32'd9, 32'd0, 32'd63, 1'b0);
    repeat (14) tick();
    #2;
    RST_N = 1'b0;
    bus.Start = 1; bus.MtHi = 1;
    #1;
    chk("midrst_busy", 64'(bus.Busy), 64'd0);
    chk("midrst_hi", 64'(bus.HI), 64'd0);
    chk("midrst_lo", 64'(bus.LO), 64'd0);
    chk("midrst_stall", 64'(bus.Stall), 64'd0);
    sb.delete();
    bus.Start = 0; bus.MtHi = 0;
    tick();
    @(negedge CLK) RST_N = 1'b1;
    tick();
    start_op(2'd1, 32'd7, 32'd9, 32'd0, 32'd63, 1'b0);
    wait_done();
    tick();

    // Start colliding with MTHI in IDLE: op wins, MT dropped, Stall raised
    bus.Start = 1; bus.Op = 2'd1; bus.Rdata1 = 32'd3; bus.Rdata2 = 32'd5;
    bus.MtHi = 1; bus.Wdata = 32'h0000_AAAA;
    #1;
    chk("start_mt_stall", 64'(bus.Stall), 64'd1);
    push_exp(2'd1, 32'd0, 32'd15, 1'b0);
    tick();
    bus.Start = 0; bus.MtHi = 0;
    chk("start_mt_hi_kept", 64'(bus.HI), 64'd0);
    wait_done();
    tick();

    // Back-to-back: each new Start issued in the Done cycle of the previous op
    start_op(2'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    wait_done();
    start_op(2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    wait_done();
    start_op(2'd1, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780, 1'b0);
    wait_done();
    repeat (3) tick();

    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL pending_ops: %0d operations still outstanding, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
